// File: rtl/z_result_stage.sv
// z_result_stage: captures 64-bit ALU results with their op codes in a small
// FIFO and streams them onto the 32-bit bus. Two-beat ops (MUL/DIV) go out
// LO word then HI word. Also keeps the ZHigh/ZLow registers, the condition
// flags of the most recent capture and a sticky illegal-op indicator.
// DEPTH must be a power of two (>= 2) and PTR_W must equal log2(DEPTH).
module z_result_stage #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      alu_result,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_hi,
  output logic             out_last,
  output logic [31:0]      z_high,
  output logic [31:0]      z_low,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             bad_op,
  output logic [PTR_W:0]   count
);

  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;

  // Entry layout: {op[3:0], result[63:0]}
  logic [67:0]      mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             beat_q, beat_d;
  logic [31:0]      z_high_q, z_high_d;
  logic [31:0]      z_low_q, z_low_d;
  logic             flag_zero_q, flag_zero_d;
  logic             flag_neg_q, flag_neg_d;
  logic             bad_op_q, bad_op_d;

  logic [67:0]      head;
  logic             head_two_beat;
  logic             in_two_beat;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             beat_adv;

  // Handshake and head-of-queue decode. Ready/valid come only from the
  // registered count, so there is no combinational path from in to out.
  always_comb begin
    full          = (count_q == (PTR_W+1)'(DEPTH));
    empty         = (count_q == '0);
    head          = mem_q[rd_ptr_q];
    head_two_beat = (head[67:64] == OP_MUL) || (head[67:64] == OP_DIV);
    in_two_beat   = (alu_op == OP_MUL) || (alu_op == OP_DIV);

    in_ready  = !full;
    out_valid = !empty;
    // Last beat when the beat counter reaches beats-1 (0 for one-beat ops).
    out_last  = out_valid && (beat_q == head_two_beat);
    out_hi    = out_valid && beat_q;
    if (!out_valid) begin
      out_data = '0;
    end else if (beat_q) begin
      out_data = head[63:32];
    end else begin
      out_data = head[31:0];
    end

    push     = in_valid && in_ready;
    beat_adv = out_valid && out_ready;
    pop      = beat_adv && out_last;
  end

  // Next-state for pointers, occupancy, beat counter and architectural regs.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_d      = beat_q;
    z_high_d    = z_high_q;
    z_low_d     = z_low_q;
    flag_zero_d = flag_zero_q;
    flag_neg_d  = flag_neg_q;
    bad_op_d    = bad_op_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      z_low_d  = alu_result[31:0];
      if (in_two_beat) begin
        z_high_d    = alu_result[63:32];
        flag_zero_d = (alu_result == 64'd0);
        flag_neg_d  = alu_result[63];
      end else begin
        flag_zero_d = (alu_result[31:0] == 32'd0);
        flag_neg_d  = alu_result[31];
      end
      if (alu_op > OP_DIV) begin
        bad_op_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      beat_d   = 1'b0;
    end else if (beat_adv) begin
      beat_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; clear discards every entry, including a half-sent one.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_q      <= 1'b0;
      z_high_q    <= '0;
      z_low_q     <= '0;
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      z_high_q    <= z_high_d;
      z_low_q     <= z_low_d;
      flag_zero_q <= flag_zero_d;
      flag_neg_q  <= flag_neg_d;
      bad_op_q    <= bad_op_d;
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {alu_op, alu_result};
    end
  end

  assign z_high    = z_high_q;
  assign z_low     = z_low_q;
  assign flag_zero = flag_zero_q;
  assign flag_neg  = flag_neg_q;
  assign bad_op    = bad_op_q;
  assign count     = count_q;

endmodule

// File: doc/z_result_stage.md
Name: z_result_stage

Overview:
- Downstream neighbour of the ALU. Captures the 64-bit ALU result together with its 4-bit op code.
- Buffers captured results in a small FIFO, then streams them onto the 32-bit datapath bus: one beat for 32-bit ops, two beats (LO then HI) for MUL/DIV.
- Also holds the architectural ZHigh/ZLow registers and the condition flags derived from the most recently captured result.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2); each entry holds {op[3:0], result[63:0]}.
- PTR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept a result; equals !full.
- alu_result  in  64  ALU result; upper 32 bits are meaningful only for op 11/12.
- alu_op  in  4  op code of alu_result (0..12 legal; 11=MUL, 12=DIV {rem,quot}).
- out_valid  out  1  bus word available; equals !empty.
- out_ready  in  1  bus consumer accepts the word.
- out_data  out  32  current beat: head LO word on beat 0, head HI word on beat 1.
- out_hi  out  1  1 when out_data is the HI beat.
- out_last  out  1  1 on the final beat of the head entry.
- z_high  out  32  ZHigh register.
- z_low  out  32  ZLow register.
- flag_zero  out  1  zero flag of the last capture.
- flag_neg  out  1  negative flag of the last capture.
- bad_op  out  1  sticky illegal-op indicator.
- count  out  PTR_W+1  number of occupied FIFO entries.

Behaviour:
- Reset (clear=0, asynchronous):
  - FIFO pointers, count, beat counter, z_high, z_low, flags and bad_op go to 0.
  - Hence out_valid=0, in_ready=1, out_data=0, out_hi=0.
  - Release is synchronous to the next clock edge.
  - Reset mid-stream discards all entries, including a half-sent two-beat entry.
- Push: when in_valid && in_ready at a rising edge:
  - Write {alu_op, alu_result} at the write pointer; write pointer increments mod DEPTH.
  - Same edge: z_low <= alu_result[31:0].
  - Same edge: z_high <= alu_result[63:32] if op is 11/12, else z_high is unchanged.
- Flags, updated only on push:
  - op 11/12: flag_zero = (alu_result == 0); flag_neg = alu_result[63].
  - Other ops: flag_zero = (alu_result[31:0] == 0); flag_neg = alu_result[31].
- Illegal op: alu_op > 12 is still accepted as a single-beat entry; bad_op is set and held until reset.
- Beats per entry: 2 if the head op is 11 or 12, otherwise 1.
- Beat sequencing:
  - A 1-bit beat counter selects out_data: beat 0 drives head[31:0], beat 1 drives head[63:32].
  - out_hi = beat; out_last = (beat == beats-1).
- Pop: on out_valid && out_ready && out_last, the read pointer increments and beat returns to 0.
- Non-last beat: on out_valid && out_ready && !out_last, beat becomes 1 and the read pointer holds.
- Stalled output: while out_valid=1 and out_ready=0, out_data, out_hi and out_last remain stable.
- Latency: a result pushed into an empty stage appears on out_data one cycle after the push edge. There is no combinational in->out bypass.
- Simultaneous push and pop: count stays unchanged and both pointers advance.
- Full: in_ready=0; in_valid is ignored. A pop in the same cycle does NOT raise in_ready that cycle (in_ready depends only on registered full).
- Empty: out_valid=0; out_ready is ignored; out_data=0.
- Pointer wrap: modulo DEPTH. Full/empty are derived from count (0..DEPTH).

Test Plan:
- Reset, then push op 3 result 64'h0000_0000_0000_0005 -> the next cycle gives out_valid=1, out_data=32'h5, out_last=1, z_low=5, flag_zero=0. Accepting with out_ready gives out_valid=0.
- Push op 11 result 64'hFFFF_FFFF_FFFF_FFFE with out_ready=1 ->
  - beat 0: out_data=32'hFFFF_FFFE, out_hi=0.
  - beat 1: out_data=32'hFFFF_FFFF, out_hi=1, out_last=1.
  - z_high=32'hFFFF_FFFF, flag_neg=1.
- out_ready=0, push three results (ops 1, 4, 12) -> first two accepted, count=2, in_ready=0, third held. Raise out_ready -> order preserved; the third enters only after the first pop.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> one entry pops, no push that cycle, count=1. Push occurs on the following edge.
- Push op 4 result 0 after an op 12 capture -> flag_zero=1, z_high keeps the op-12 remainder, z_low=0.
- Push op 15 -> bad_op=1 and stays 1 after later legal ops. Assert clear=0 midway through a two-beat DIV readout -> outputs zero immediately, out_valid=0, bad_op=0.
